alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Request/response front end for the 32-bit combinational ALU (ports out, cout, zero, overflow, a, b, op). Accepts one operation at a time over a valid/ready request channel and drives registered operands onto the ALU. Waits a fixed settle interval, then captures the ALU flags and result and returns them over a valid/ready response channel. Optionally compares the result against an expected value and keeps running pass/total counts, giving a hardware-resident self-check of the ALU.

Parameters:
SETTLE_CYCLES, 4, clock edges between operand launch and result capture; legal range >=1
CNT_WIDTH, 16, width of the tests and passed counters

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  3  ALU op: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
req_a  input  32  operand A
req_b  input  32  operand B
req_exp  input  32  expected result
req_check  input  1  1 = compare result with req_exp and update counters
alu_a  output  32  registered operand A to ALU
alu_b  output  32  registered operand B to ALU
alu_op  output  3  registered op to ALU
alu_out  input  32  ALU result
alu_cout  input  1  ALU carry out
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_out  output  32  captured result
rsp_cout  output  1  captured carry
rsp_zero  output  1  captured zero
rsp_overflow  output  1  captured overflow
rsp_pass  output  1  1 = check requested and rsp_out == expected
clr_stats  input  1  synchronous clear of both counters
tests_cnt  output  CNT_WIDTH  checked operations completed
passed_cnt  output  CNT_WIDTH  checked operations that matched

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, all alu_* = 0, all rsp_* = 0, both counters = 0, settle counter = 0. Reset asserted mid-operation aborts it with no response and no counter update.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1:
  - register req_a/req_b/req_op into alu_a/alu_b/alu_op;
  - register req_exp and req_check internally;
  - settle counter = SETTLE_CYCLES-1;
  - go to DRIVE.
- DRIVE: req_ready=0. Each edge, if the settle counter is non-zero, decrement it. If it is 0:
  - capture alu_out/cout/zero/overflow into rsp_*;
  - rsp_pass = check & (alu_out == exp), as a full 32-bit compare;
  - set rsp_valid=1 and go to RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accepting edge (4 by default).
- RESP: req_ready=0. rsp_* hold stable while rsp_valid=1 and rsp_ready=0. On an edge with rsp_ready=1, clear rsp_valid and go to IDLE. No request is accepted on that same edge; the next accept is possible one edge later.
- alu_a/b/op hold their last values in all states until the next accept.
- Counters update on the capture edge only, and only when check=1:
  - tests_cnt increments;
  - passed_cnt increments if matched;
  - each counter saturates at all-ones (no wrap).
- clr_stats=1 on an edge zeroes both counters. If it coincides with a capture edge, the clear wins and that operation is not counted. Response data is unaffected.
- rsp_pass=0 whenever check=0, regardless of data.
- The block does no ALU arithmetic itself; flags are sampled as presented by the ALU.

Test Plan:
- XOR zero operands: op=010, a=0, b=0, exp=0, check=1, rsp_ready=1 -> rsp_valid 4 edges after accept; rsp_out=0, rsp_zero=1, rsp_pass=1; tests_cnt=1, passed_cnt=1.
- Mismatch: op=000, a=0x7FFFFFFF, b=1, exp=0 -> rsp_out=0x80000000, rsp_overflow=1, rsp_pass=0; tests_cnt increments, passed_cnt unchanged.
- Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout; a new req_valid is ignored until one edge after the rsp_ready=1 handshake.
- Reset mid-DRIVE: pull reset_n low 2 edges after accept -> outputs go to reset values immediately, no response, counters 0.
- Saturation/clear: CNT_WIDTH=2, 5 checked passing ops -> both counters stop at 3. Then assert clr_stats on a capture edge -> counters 0, and that op is not counted.
- SETTLE_CYCLES=1, check=0, op=111, a=0xF0F0F0F0, b=0x0F0F0F0F -> rsp_valid 1 edge after accept, rsp_out=0xFFFFFFFF, rsp_pass=0, counters unchanged.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request and response channels between an operation source and the ALU sequencer.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] req_exp;
    logic        req_check;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_pass;

    modport master (
        output req_valid, req_op, req_a, req_b, req_exp, req_check, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_cout, rsp_zero, rsp_overflow, rsp_pass
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_exp, req_check, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_cout, rsp_zero, rsp_overflow, rsp_pass
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front end for a combinational 32-bit ALU: launches registered operands,
// waits a fixed settle time, captures result/flags and returns them, and
// optionally scores the result against an expected value.
//
// state | meaning
// IDLE  | ready for a request; ALU operands hold the previous operation
// DRIVE | operands on the ALU, settle counter running down to zero
// RESP  | captured response presented until the consumer takes it
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_op_sequencer_if.slave    bus,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_out,
    input  logic                 alu_cout,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] tests_cnt,
    output logic [CNT_WIDTH-1:0] passed_cnt
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [31:0]   exp_q;
    logic          check_q;
    logic          capture;
    logic          match;

    // Capture happens on the DRIVE edge where the settle count has run out.
    assign capture = (state == DRIVE) && (settle_cnt == '0);
    assign match   = (alu_out == exp_q);

    // Sequencer FSM with registered handshake, operand and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            exp_q            <= '0;
            check_q          <= 1'b0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_op           <= '0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_out      <= '0;
            bus.rsp_cout     <= 1'b0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        alu_a         <= bus.req_a;
                        alu_b         <= bus.req_b;
                        alu_op        <= bus.req_op;
                        exp_q         <= bus.req_exp;
                        check_q       <= bus.req_check;
                        settle_cnt    <= SETTLE_LOAD;
                        bus.req_ready <= 1'b0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else begin
                        bus.rsp_out      <= alu_out;
                        bus.rsp_cout     <= alu_cout;
                        bus.rsp_zero     <= alu_zero;
                        bus.rsp_overflow <= alu_overflow;
                        bus.rsp_pass     <= check_q & match;
                        bus.rsp_valid    <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    // Ready returns with the handshake, so the earliest new accept is the following edge.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating self-check counters; a clear outranks a same-edge capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tests_cnt  <= '0;
            passed_cnt <= '0;
        end else if (clr_stats) begin
            tests_cnt  <= '0;
            passed_cnt <= '0;
        end else if (capture && check_q) begin
            if (tests_cnt != CNT_MAX) begin
                tests_cnt <= tests_cnt + CNT_ONE;
            end
            if (match && (passed_cnt != CNT_MAX)) begin
                passed_cnt <= passed_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (default settle/counter widths,
// and SETTLE_CYCLES=1 with 2-bit counters), each fed by a behavioural ALU.
// Expected responses are queued at accept time and checked by a monitor.
module tb_alu_op_sequencer;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        pass;
        int          lat;
        int          acc;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic        rst_n_d     [2];
    logic        req_valid_d [2];
    logic [2:0]  req_op_d    [2];
    logic [31:0] req_a_d     [2];
    logic [31:0] req_b_d     [2];
    logic [31:0] req_exp_d   [2];
    logic        req_check_d [2];
    logic        rsp_ready_d [2];
    logic        clr_d       [2];

    logic        req_ready_d [2];
    logic        rsp_valid_d [2];
    logic [31:0] rsp_out_d   [2];
    logic        rsp_cout_d  [2];
    logic        rsp_zero_d  [2];
    logic        rsp_ovf_d   [2];
    logic        rsp_pass_d  [2];

    logic [31:0] alu_a_d     [2];
    logic [31:0] alu_b_d     [2];
    logic [2:0]  alu_op_d    [2];
    logic [31:0] alu_out_d   [2];
    logic        alu_cout_d  [2];
    logic        alu_zero_d  [2];
    logic        alu_ovf_d   [2];

    logic [15:0] tests0, passed0;
    logic [1:0]  tests1, passed1;

    rsp_t sbq0[$];
    rsp_t sbq1[$];
    bit   prev_v    [2];
    int   first_cyc [2];
    int   last_hs   [2];

    alu_op_sequencer_if bus0 ();
    alu_op_sequencer_if bus1 ();

    assign bus0.req_valid = req_valid_d[0];
    assign bus0.req_op    = req_op_d[0];
    assign bus0.req_a     = req_a_d[0];
    assign bus0.req_b     = req_b_d[0];
    assign bus0.req_exp   = req_exp_d[0];
    assign bus0.req_check = req_check_d[0];
    assign bus0.rsp_ready = rsp_ready_d[0];
    assign req_ready_d[0] = bus0.req_ready;
    assign rsp_valid_d[0] = bus0.rsp_valid;
    assign rsp_out_d[0]   = bus0.rsp_out;
    assign rsp_cout_d[0]  = bus0.rsp_cout;
    assign rsp_zero_d[0]  = bus0.rsp_zero;
    assign rsp_ovf_d[0]   = bus0.rsp_overflow;
    assign rsp_pass_d[0]  = bus0.rsp_pass;

    assign bus1.req_valid = req_valid_d[1];
    assign bus1.req_op    = req_op_d[1];
    assign bus1.req_a     = req_a_d[1];
    assign bus1.req_b     = req_b_d[1];
    assign bus1.req_exp   = req_exp_d[1];
    assign bus1.req_check = req_check_d[1];
    assign bus1.rsp_ready = rsp_ready_d[1];
    assign req_ready_d[1] = bus1.req_ready;
    assign rsp_valid_d[1] = bus1.rsp_valid;
    assign rsp_out_d[1]   = bus1.rsp_out;
    assign rsp_cout_d[1]  = bus1.rsp_cout;
    assign rsp_zero_d[1]  = bus1.rsp_zero;
    assign rsp_ovf_d[1]   = bus1.rsp_overflow;
    assign rsp_pass_d[1]  = bus1.rsp_pass;

    alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_WIDTH(16)) u_dut0 (
        .clk          (clk),
        .reset_n      (rst_n_d[0]),
        .bus          (bus0.slave),
        .alu_a        (alu_a_d[0]),
        .alu_b        (alu_b_d[0]),
        .alu_op       (alu_op_d[0]),
        .alu_out      (alu_out_d[0]),
        .alu_cout     (alu_cout_d[0]),
        .alu_zero     (alu_zero_d[0]),
        .alu_overflow (alu_ovf_d[0]),
        .clr_stats    (clr_d[0]),
        .tests_cnt    (tests0),
        .passed_cnt   (passed0)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_WIDTH(2)) u_dut1 (
        .clk          (clk),
        .reset_n      (rst_n_d[1]),
        .bus          (bus1.slave),
        .alu_a        (alu_a_d[1]),
        .alu_b        (alu_b_d[1]),
        .alu_op       (alu_op_d[1]),
        .alu_out      (alu_out_d[1]),
        .alu_cout     (alu_cout_d[1]),
        .alu_zero     (alu_zero_d[1]),
        .alu_overflow (alu_ovf_d[1]),
        .clr_stats    (clr_d[1]),
        .tests_cnt    (tests1),
        .passed_cnt   (passed1)
    );

    // Behavioural ALU: returns {out, cout, zero, overflow}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] o;
        logic        c;
        logic        v;
        s = '0;
        o = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (o[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (o[31] != a[31]);
            end
            3'd2: o = a ^ b;
            3'd3: o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: o = a & b;
            3'd5: o = ~(a & b);
            3'd6: o = ~(a | b);
            default: o = a | b;
        endcase
        return {o, c, (o == 32'd0), v};
    endfunction

    assign {alu_out_d[0], alu_cout_d[0], alu_zero_d[0], alu_ovf_d[0]} = alu_f(alu_a_d[0], alu_b_d[0], alu_op_d[0]);
    assign {alu_out_d[1], alu_cout_d[1], alu_zero_d[1], alu_ovf_d[1]} = alu_f(alu_a_d[1], alu_b_d[1], alu_op_d[1]);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: stall checks against the queue head, full compare on handshake.
    always @(negedge clk) begin
        rsp_t e;
        int   qsz;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid_d[d] && !prev_v[d]) first_cyc[d] = cyc;
            prev_v[d] = rsp_valid_d[d];
            if (rsp_valid_d[d]) begin
                check($sformatf("dut%0d.req_ready_in_resp", d), 32'(req_ready_d[d]), 32'd0);
                qsz = (d == 0) ? sbq0.size() : sbq1.size();
                if (qsz == 0) begin
                    n_checks++;
                    $display("FAIL dut%0d.unexpected_rsp: got rsp_valid=1 out=0x%08h, expected no response", d, rsp_out_d[d]);
                end else begin
                    e = (d == 0) ? sbq0[0] : sbq1[0];
                    if (!rsp_ready_d[d]) begin
                        check($sformatf("%s.stall_out", e.name), rsp_out_d[d], e.out);
                        check($sformatf("%s.stall_pass", e.name), 32'(rsp_pass_d[d]), 32'(e.pass));
                    end else begin
                        if (d == 0) void'(sbq0.pop_front());
                        else        void'(sbq1.pop_front());
                        last_hs[d] = cyc + 1;
                        check($sformatf("%s.out", e.name), rsp_out_d[d], e.out);
                        check($sformatf("%s.cout", e.name), 32'(rsp_cout_d[d]), 32'(e.cout));
                        check($sformatf("%s.zero", e.name), 32'(rsp_zero_d[d]), 32'(e.zero));
                        check($sformatf("%s.ovf", e.name), 32'(rsp_ovf_d[d]), 32'(e.ovf));
                        check($sformatf("%s.pass", e.name), 32'(rsp_pass_d[d]), 32'(e.pass));
                        check($sformatf("%s.latency", e.name), 32'(first_cyc[d] - e.acc), 32'(e.lat));
                    end
                end
            end
        end
    end

    // Present one request, wait (bounded) for its accept edge, queue the expected response.
    task automatic send(input int d, input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ex, input logic ck,
                        input logic [31:0] eo, input logic ec, input logic ez, input logic ev,
                        input logic ep, input bit push, output int acc);
        rsp_t r;
        int   n;
        bit   ok;
        req_op_d[d]    = op;
        req_a_d[d]     = a;
        req_b_d[d]     = b;
        req_exp_d[d]   = ex;
        req_check_d[d] = ck;
        req_valid_d[d] = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = req_ready_d[d];
            @(posedge clk);
            n++;
        end
        #1;
        req_valid_d[d] = 1'b0;
        acc = cyc;
        if (!ok) begin
            n_checks++;
            $display("FAIL %s.accept_timeout: got req_ready=0 for %0d cycles, expected accept", nm, n);
        end else if (push) begin
            r.name = nm;
            r.out  = eo;
            r.cout = ec;
            r.zero = ez;
            r.ovf  = ev;
            r.pass = ep;
            r.lat  = (d == 0) ? 4 : 1;
            r.acc  = acc;
            if (d == 0) sbq0.push_back(r);
            else        sbq1.push_back(r);
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? sbq0.size() : sbq1.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 200) begin
            n_checks++;
            $display("FAIL dut%0d.drain_timeout: got %0d pending responses, expected 0", d, (d == 0) ? sbq0.size() : sbq1.size());
            if (d == 0) sbq0.delete();
            else        sbq1.delete();
        end
    endtask

    initial begin
        int acc;
        int n;
        for (int d = 0; d < 2; d++) begin
            rst_n_d[d]     = 1'b0;
            req_valid_d[d] = 1'b0;
            req_op_d[d]    = '0;
            req_a_d[d]     = '0;
            req_b_d[d]     = '0;
            req_exp_d[d]   = '0;
            req_check_d[d] = 1'b0;
            rsp_ready_d[d] = 1'b1;
            clr_d[d]       = 1'b0;
        end
        @(posedge clk);
        #1;
        check("reset.req_ready", 32'(req_ready_d[0]), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid_d[0]), 32'd0);
        check("reset.alu_a", alu_a_d[0], 32'd0);
        check("reset.rsp_out", rsp_out_d[0], 32'd0);
        check("reset.tests", 32'(tests0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_d[0] = 1'b1;
        rst_n_d[1] = 1'b1;
        @(posedge clk);
        #1;

        // Default instance: one op of each kind, flags and pass hand-computed.
        send(0, "xor_zero", 3'd2, 32'h0,        32'h0,        32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        send(0, "add_ovf",  3'd0, 32'h7FFFFFFF, 32'h1,        32'h0,        1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        send(0, "sub_neg",  3'd1, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        send(0, "slt_sgn",  3'd3, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        send(0, "and_nchk", 3'd4, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        send(0, "nand_one", 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        send(0, "nor_miss", 3'd6, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        send(0, "add_wrap", 3'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        drain(0);
        check("dut0.tests_after_8", 32'(tests0), 32'd7);
        check("dut0.passed_after_8", 32'(passed0), 32'd5);

        // Backpressure: response stalled 10 cycles while a new request waits.
        rsp_ready_d[0] = 1'b0;
        send(0, "bp_sub", 3'd1, 32'h10, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        req_op_d[0]    = 3'd7;
        req_a_d[0]     = 32'h12340000;
        req_b_d[0]     = 32'h00005678;
        req_exp_d[0]   = 32'h12345678;
        req_check_d[0] = 1'b1;
        req_valid_d[0] = 1'b1;
        n = 0;
        while (!rsp_valid_d[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp.rsp_valid_seen", 32'(rsp_valid_d[0]), 32'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp.rsp_valid_held", 32'(rsp_valid_d[0]), 32'd1);
            check("bp.alu_a_held", alu_a_d[0], 32'h10);
        end
        rsp_ready_d[0] = 1'b1;
        send(0, "bp_or", 3'd7, 32'h12340000, 32'h00005678, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        check("bp.accept_gap", 32'(acc - last_hs[0]), 32'd1);
        drain(0);
        check("dut0.tests_after_bp", 32'(tests0), 32'd9);
        check("dut0.passed_after_bp", 32'(passed0), 32'd7);

        // Reset two edges into DRIVE aborts the operation.
        send(0, "rst_abort", 3'd1, 32'h9, 32'h3, 32'h6, 1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        rst_n_d[0] = 1'b0;
        #1;
        check("rst_mid.rsp_valid", 32'(rsp_valid_d[0]), 32'd0);
        check("rst_mid.req_ready", 32'(req_ready_d[0]), 32'd1);
        check("rst_mid.alu_a", alu_a_d[0], 32'd0);
        check("rst_mid.alu_b", alu_b_d[0], 32'd0);
        check("rst_mid.alu_op", 32'(alu_op_d[0]), 32'd0);
        check("rst_mid.tests", 32'(tests0), 32'd0);
        check("rst_mid.passed", 32'(passed0), 32'd0);
        @(posedge clk);
        #1;
        rst_n_d[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid.no_rsp_later", 32'(rsp_valid_d[0]), 32'd0);
        check("rst_mid.tests_later", 32'(tests0), 32'd0);

        // SETTLE_CYCLES=1, 2-bit counters: saturation, clear on capture, unchecked op.
        for (int i = 0; i < 5; i++) begin
            send(1, "sat_xor", 3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        end
        drain(1);
        check("sat.tests", 32'(tests1), 32'd3);
        check("sat.passed", 32'(passed1), 32'd3);

        send(1, "clr_cap", 3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        clr_d[1] = 1'b1;
        @(posedge clk);
        #1;
        clr_d[1] = 1'b0;
        check("clr_cap.tests", 32'(tests1), 32'd0);
        check("clr_cap.passed", 32'(passed1), 32'd0);
        drain(1);

        send(1, "or_nchk", 3'd7, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        drain(1);
        check("or_nchk.tests", 32'(tests1), 32'd0);
        check("or_nchk.passed", 32'(passed1), 32'd0);

        send(1, "add_miss", 3'd0, 32'h1, 32'h1, 32'h3, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        drain(1);
        check("add_miss.tests", 32'(tests1), 32'd1);
        check("add_miss.passed", 32'(passed1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
